// File: rtl/mmio_fabric.sv
// mmio_fabric: registered CPU-to-peripheral bus with per-device address windows,
// window-offset translation, ack handshake with wait states and a bus-error timeout.

// Per-device window decoder. It reports a hit and the offset of the address
// inside the window.
module mmio_win_dec #(
  parameter logic [15:0] BASE = 16'h0000,
  parameter logic [4:0]  SZ   = 5'd16
) (
  input  logic [15:0] addr,
  output logic        hit,
  output logic [15:0] off
);
  // A size of 16 shifts everything out, so the whole space matches.
  localparam logic [15:0] BASE_HI = BASE >> SZ;
  localparam logic [15:0] MASK    = 16'((17'd1 << SZ) - 17'd1);

  assign hit = (addr >> SZ) == BASE_HI;
  assign off = addr & MASK;
endmodule

module mmio_fabric #(
  parameter int NUM_DEV = 4,
  // Device i sits in bits [16i+15:16i]. The list is written highest index first,
  // so device 0 is at 0x0000, device 1 at 0x8000, device 2 at 0xC000 and
  // device 3 at 0xD000.
  parameter logic [NUM_DEV*16-1:0] DEV_BASE      = {16'hD000, 16'hC000, 16'h8000, 16'h0000},
  parameter logic [NUM_DEV*5-1:0]  DEV_SIZE_LOG2 = {5'd4, 5'd4, 5'd14, 5'd15},
  parameter int TIMEOUT = 16,
  parameter logic [7:0] ERR_DATA = 8'hFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          cpu_addr,
  input  logic                 cpu_rd,
  input  logic                 cpu_wr,
  input  logic [7:0]           cpu_wdata,
  output logic [7:0]           cpu_rdata,
  output logic                 cpu_ready,
  output logic                 cpu_err,
  output logic                 cpu_busy,
  output logic [NUM_DEV-1:0]   dev_sel,
  output logic [15:0]          dev_addr,
  output logic                 dev_rd,
  output logic                 dev_wr,
  output logic [7:0]           dev_wdata,
  input  logic [NUM_DEV*8-1:0] dev_rdata,
  input  logic [NUM_DEV-1:0]   dev_ack
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [7:0] TO8 = 8'(TIMEOUT);

  state_t                     state;
  logic [7:0]                 cnt;
  logic [7:0]                 cnt_nxt;
  logic                       is_rd;
  logic [NUM_DEV-1:0]         hit;
  logic [NUM_DEV-1:0][15:0]   off;
  logic [NUM_DEV-1:0]         hit_pri;
  logic                       any_hit;
  logic [15:0]                off_sel;
  logic                       sel_ack;
  logic [7:0]                 sel_rdata;

  for (genvar g = 0; g < NUM_DEV; g++) begin : g_dec
    mmio_win_dec #(
      .BASE (DEV_BASE[16*g +: 16]),
      .SZ   (DEV_SIZE_LOG2[5*g +: 5])
    ) u_dec (
      .addr (cpu_addr),
      .hit  (hit[g]),
      .off  (off[g])
    );
  end

  // Overlapping windows: the lowest device index takes the access.
  always_comb begin
    hit_pri = '0;
    any_hit = 1'b0;
    off_sel = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (hit[i] && !any_hit) begin
        hit_pri[i] = 1'b1;
        off_sel    = off[i];
        any_hit    = 1'b1;
      end
    end
  end

  // Only the selected device's ack and read data are looked at.
  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (dev_sel[i]) begin
        sel_ack   = dev_ack[i];
        sel_rdata = dev_rdata[8*i +: 8];
      end
    end
  end

  // Saturating wait counter; it never wraps back to zero.
  assign cnt_nxt = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  // Transaction FSM with registered bus outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      is_rd     <= 1'b0;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_busy  <= 1'b0;
      dev_sel   <= '0;
      dev_addr  <= '0;
      dev_rd    <= 1'b0;
      dev_wr    <= 1'b0;
      dev_wdata <= '0;
    end else begin
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_rd || cpu_wr) begin
            cpu_busy  <= 1'b1;
            is_rd     <= cpu_rd;
            dev_addr  <= off_sel;
            dev_wdata <= cpu_wdata;
            cnt       <= '0;
            // A miss or a simultaneous read+write never reaches a device.
            // The simultaneous case is answered like an errored read.
            if ((cpu_rd && cpu_wr) || !any_hit) begin
              state     <= RESP;
              cpu_ready <= 1'b1;
              cpu_err   <= 1'b1;
              if (cpu_rd) cpu_rdata <= ERR_DATA;
            end else begin
              state   <= ACCESS;
              dev_sel <= hit_pri;
              dev_rd  <= cpu_rd;
              dev_wr  <= cpu_wr;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt_nxt;
          // An ack wins over a timeout that expires in the same cycle.
          if (sel_ack || cnt_nxt >= TO8) begin
            state     <= RESP;
            dev_sel   <= '0;
            dev_rd    <= 1'b0;
            dev_wr    <= 1'b0;
            cpu_ready <= 1'b1;
            cpu_err   <= !sel_ack;
            if (is_rd) cpu_rdata <= sel_ack ? sel_rdata : ERR_DATA;
          end
        end
        RESP: begin
          state    <= IDLE;
          cpu_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_fabric.sv
// Bench for mmio_fabric: a transaction-level model predicts every output per cycle;
// directed tests add hand-computed literal checks.
module tb_mmio_fabric;
  localparam int ND = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   cpu_addr;
  logic          cpu_rd, cpu_wr;
  logic [7:0]    cpu_wdata;
  logic [7:0]    cpu_rdata;
  logic          cpu_ready, cpu_err, cpu_busy;
  logic [ND-1:0] dev_sel;
  logic [15:0]   dev_addr;
  logic          dev_rd, dev_wr;
  logic [7:0]    dev_wdata;
  logic [ND*8-1:0] dev_rdata;
  logic [ND-1:0] dev_ack;

  logic [7:0] dev_data [ND];
  assign dev_rdata = {dev_data[3], dev_data[2], dev_data[1], dev_data[0]};

  mmio_fabric dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .cpu_busy(cpu_busy), .dev_sel(dev_sel), .dev_addr(dev_addr), .dev_rd(dev_rd),
    .dev_wr(dev_wr), .dev_wdata(dev_wdata), .dev_rdata(dev_rdata), .dev_ack(dev_ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c0    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Device responder: the planned device acks plan_k cycles after the strobe starts;
  // optionally device 0 acks stray on every strobe cycle.
  int   plan_k;
  int   plan_dev;
  logic plan_stray;
  int   age = -1;

  always @(posedge clk) begin
    #1;
    dev_ack = '0;
    if (reset || !(dev_rd || dev_wr)) age = -1;
    else begin
      age = age + 1;
      if (age == plan_k) dev_ack[plan_dev] = 1'b1;
      if (plan_stray) dev_ack[0] = 1'b1;
    end
  end

  // Memory map as the model sees it.
  int base [ND] = '{'h0000, 'h8000, 'hC000, 'hD000};
  int sz   [ND] = '{15, 14, 4, 4};

  function automatic int decode(input logic [15:0] a, output logic [15:0] o);
    o = '0;
    for (int i = 0; i < ND; i++)
      if (int'(a) >= base[i] && int'(a) < base[i] + (1 << sz[i])) begin
        o = 16'(int'(a) - base[i]);
        return i;
      end
    return -1;
  endfunction

  // Model state: one transaction described by its start cycle and its planned ack delay.
  logic        rec_v = 1'b0, rec_pre, rec_rd;
  int          rec_c0, rec_dev, rec_k;
  logic [15:0] rec_off;
  logic [7:0]  rec_wd, rec_data;
  logic [7:0]  exp_rdata = 8'h00;
  int          rel, len, endc, d;
  logic        ok;
  logic        e_busy, e_ready, e_err, e_rd, e_wr, e_strobe;
  logic [ND-1:0] e_sel;
  logic [15:0] o_tmp;

  // Compare process: predict this cycle's outputs, check them, then accept a new request.
  always @(negedge clk) begin
    e_busy = 0; e_ready = 0; e_err = 0; e_rd = 0; e_wr = 0; e_strobe = 0; e_sel = '0;
    if (reset) begin
      rec_v = 1'b0;
      exp_rdata = 8'h00;
    end else if (rec_v) begin
      rel  = cyc - rec_c0;
      ok   = !rec_pre && rec_k >= 0 && rec_k <= TO - 1;
      len  = ok ? rec_k : TO - 1;
      endc = rec_pre ? 1 : 2 + len;
      if (rel >= 1 && rel <= endc) e_busy = 1'b1;
      if (rel == endc) begin
        e_ready = 1'b1;
        e_err   = !ok;
        if (rec_rd) exp_rdata = ok ? rec_data : 8'hFF;
      end
      if (!rec_pre && rel >= 1 && rel <= 1 + len) begin
        e_strobe = 1'b1;
        e_sel    = ND'(1 << rec_dev);
        e_rd     = rec_rd;
        e_wr     = !rec_rd;
      end
      if (rel >= endc) rec_v = 1'b0;
    end
    chk("busy",  32'(cpu_busy),  32'(e_busy));
    chk("ready", 32'(cpu_ready), 32'(e_ready));
    chk("err",   32'(cpu_err),   32'(e_err));
    chk("sel",   32'(dev_sel),   32'(e_sel));
    chk("dev_rd", 32'(dev_rd),   32'(e_rd));
    chk("dev_wr", 32'(dev_wr),   32'(e_wr));
    chk("rdata", 32'(cpu_rdata), 32'(exp_rdata));
    if (e_strobe) begin
      chk("daddr", 32'(dev_addr),  32'(rec_off));
      chk("wdata", 32'(dev_wdata), 32'(rec_wd));
    end
    if (!reset && !e_busy && (cpu_rd || cpu_wr)) begin
      d        = decode(cpu_addr, o_tmp);
      rec_v    = 1'b1;
      rec_c0   = cyc;
      rec_pre  = (cpu_rd && cpu_wr) || d < 0;
      rec_rd   = cpu_rd;
      rec_dev  = (d < 0) ? 0 : d;
      rec_off  = o_tmp;
      rec_wd   = cpu_wdata;
      rec_data = dev_data[rec_dev];
      rec_k    = (plan_dev == rec_dev) ? plan_k : ((plan_stray && rec_dev == 0) ? 0 : -1);
    end
  end

  task automatic issue(input logic [15:0] a, input logic r, input logic w, input logic [7:0] wd);
    @(posedge clk); #1;
    cpu_addr = a; cpu_rd = r; cpu_wr = w; cpu_wdata = wd; c0 = cyc;
    @(posedge clk); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic wait_ready(input int maxc, output int lat, output int sc, output logic [3:0] s,
                            output logic [15:0] a, output logic [7:0] wd,
                            output logic [7:0] rd, output logic er);
    sc = 0; lat = -1; s = '0; a = '0; wd = '0; rd = '0; er = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (dev_rd || dev_wr) begin
        if (sc == 0) begin s = dev_sel; a = dev_addr; wd = dev_wdata; end
        sc++;
      end
      if (cpu_ready) begin
        lat = cyc - c0; rd = cpu_rdata; er = cpu_err;
        break;
      end
    end
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL ready_wait: no cpu_ready within %0d cycles", maxc);
    end
  endtask

  int lat, sc, nready;
  logic [3:0]  s;
  logic [15:0] a;
  logic [7:0]  wd, rd;
  logic        er;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cpu_addr = '0; cpu_rd = 0; cpu_wr = 0; cpu_wdata = '0; dev_ack = '0;
    plan_k = -1; plan_dev = 0; plan_stray = 1'b0;
    dev_data[0] = 8'h11; dev_data[1] = 8'h22; dev_data[2] = 8'h33; dev_data[3] = 8'h44;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", 32'(cpu_rdata), 32'h0);
    chk("rst_busy",  32'(cpu_busy),  32'h0);
    chk("rst_sel",   32'(dev_sel),   32'h0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Test 1: reset while a read is waiting in ACCESS, then a normal read.
    plan_dev = 0; plan_k = -1;
    issue(16'h0010, 1, 0, 8'h00);
    repeat (3) @(negedge clk);
    chk("t1_rd_held", 32'(dev_rd), 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("t1_rst_rd",    32'(dev_rd),    32'h0);
    chk("t1_rst_sel",   32'(dev_sel),   32'h0);
    chk("t1_rst_busy",  32'(cpu_busy),  32'h0);
    chk("t1_rst_ready", 32'(cpu_ready), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    plan_k = 0; dev_data[0] = 8'h5A;
    issue(16'h0010, 1, 0, 8'h00);
    wait_ready(40, lat, sc, s, a, wd, rd, er);
    chk("t1_lat",   32'(lat), 32'd2);
    chk("t1_rdata", 32'(rd),  32'h5A);
    chk("t1_err",   32'(er),  32'h0);
    repeat (2) @(posedge clk);

    // Test 2: zero-wait read from device 1.
    plan_dev = 1; plan_k = 0; dev_data[1] = 8'hA5;
    issue(16'h8005, 1, 0, 8'h00);
    wait_ready(40, lat, sc, s, a, wd, rd, er);
    chk("t2_lat",   32'(lat), 32'd2);
    chk("t2_sel",   32'(s),   32'b0010);
    chk("t2_addr",  32'(a),   32'h0005);
    chk("t2_rdata", 32'(rd),  32'hA5);
    chk("t2_err",   32'(er),  32'h0);
    repeat (2) @(posedge clk);

    // Test 3: write with four wait states to device 2; read data stays untouched.
    plan_dev = 2; plan_k = 4;
    issue(16'hC003, 0, 1, 8'h3C);
    wait_ready(40, lat, sc, s, a, wd, rd, er);
    chk("t3_lat",    32'(lat), 32'd6);
    chk("t3_strobe", 32'(sc),  32'd5);
    chk("t3_sel",    32'(s),   32'b0100);
    chk("t3_addr",   32'(a),   32'h0003);
    chk("t3_wdata",  32'(wd),  32'h3C);
    chk("t3_err",    32'(er),  32'h0);
    chk("t3_rdata",  32'(rd),  32'hA5);
    repeat (2) @(posedge clk);

    // Test 4: decode miss.
    issue(16'hE000, 1, 0, 8'h00);
    wait_ready(40, lat, sc, s, a, wd, rd, er);
    chk("t4_lat",    32'(lat), 32'd1);
    chk("t4_strobe", 32'(sc),  32'd0);
    chk("t4_err",    32'(er),  32'h1);
    chk("t4_rdata",  32'(rd),  32'hFF);
    repeat (2) @(posedge clk);

    // Test 5: device 3 never acks; device 0 acks stray throughout.
    dev_data[1] = 8'h00;
    plan_dev = 3; plan_k = -1; plan_stray = 1'b1;
    issue(16'hD000, 1, 0, 8'h00);
    wait_ready(40, lat, sc, s, a, wd, rd, er);
    chk("t5_strobe", 32'(sc),  32'd16);
    chk("t5_lat",    32'(lat), 32'd17);
    chk("t5_sel",    32'(s),   32'b1000);
    chk("t5_err",    32'(er),  32'h1);
    chk("t5_rdata",  32'(rd),  32'hFF);
    plan_stray = 1'b0;
    repeat (2) @(posedge clk);

    // Test 6a: read and write requested together.
    issue(16'h8000, 1, 1, 8'h77);
    wait_ready(40, lat, sc, s, a, wd, rd, er);
    chk("t6_lat",    32'(lat), 32'd1);
    chk("t6_err",    32'(er),  32'h1);
    chk("t6_strobe", 32'(sc),  32'd0);
    repeat (2) @(posedge clk);

    // Test 6b: a second read while busy is dropped; exactly one ready pulse.
    plan_dev = 1; plan_k = 3; dev_data[1] = 8'h6B; dev_data[2] = 8'hC2;
    issue(16'h8001, 1, 0, 8'h00);
    cpu_addr = 16'hC000; cpu_rd = 1'b1;
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    nready = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cpu_ready) nready++;
    end
    chk("t6_nready", 32'(nready),    32'd1);
    chk("t6_rdata",  32'(cpu_rdata), 32'h6B);
    chk("t6_idle",   32'(cpu_busy),  32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
